// File: rtl/unified_mem_arbiter_pkg.sv
// Shared types for the unified memory arbiter.
//   arb_state_e : sequencing states of the single-access FSM
//   CNT_W       : width of the fetch-starvation counter (limits 1..15)
//   arb_can_grant() : true in the states that may launch a new access
package unified_mem_arbiter_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [2:0] {
    ARB_IDLE,
    ARB_ISSUE_I,
    ARB_ISSUE_D,
    ARB_DONE_I,
    ARB_DONE_D
  } arb_state_e;

  function automatic logic arb_can_grant(arb_state_e s);
    return (s == ARB_IDLE) || (s == ARB_DONE_I) || (s == ARB_DONE_D);
  endfunction

endpackage

// File: rtl/unified_mem_arb_grant.sv
// Grant decision for the unified memory arbiter plus the fetch-starvation
// counter.
//   clk, rst              : clock, async active-low reset
//   inst_req, data_req    : raw request lines from the two CPU ports
//   excl_inst, excl_data  : port currently completing; must not be re-granted
//   grant_en              : FSM is in a state that may launch an access
//   grant_inst, grant_data: one-hot (or zero) grant for this cycle
module unified_mem_arb_grant
  import unified_mem_arbiter_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inst_req,
  input  logic data_req,
  input  logic excl_inst,
  input  logic excl_data,
  input  logic grant_en,
  output logic grant_inst,
  output logic grant_data
);

  logic [CNT_W-1:0] starve_cnt;
  logic             inst_ok;
  logic             data_ok;
  logic             starved;

  assign inst_ok = grant_en & inst_req & ~excl_inst;
  assign data_ok = grant_en & data_req & ~excl_data;
  assign starved = (starve_cnt == CNT_W'(STARVE_LIMIT));

  // Data wins contention unless the fetch has waited out STARVE_LIMIT grants.
  always_comb begin
    grant_inst = 1'b0;
    grant_data = 1'b0;
    if (inst_ok && data_ok) begin
      if (starved) grant_inst = 1'b1;
      else         grant_data = 1'b1;
    end else begin
      grant_inst = inst_ok;
      grant_data = data_ok;
    end
  end

  // Counts data grants made while a fetch is asserted (even one that is
  // excluded this cycle); saturates so an excluded fetch cannot wrap it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                         starve_cnt <= '0;
    else if (!inst_req || grant_inst) starve_cnt <= '0;
    else if (grant_data && !starved)  starve_cnt <= starve_cnt + 1'b1;
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Shares one single-port synchronous-read memory between the instruction
// fetch port and the data (load/store) port, one access at a time.
//   clk, rst          : clock, async active-low reset
//   inst_*            : fetch request (ce/addr) and completion (data/rdy)
//   data_*            : load/store request (ce/we/sel/addr/wdata), completion
//   mem_*_o           : registered memory command; mem_rdata_i valid the
//                       cycle after mem_ce_o
//   stall_req_o       : pipeline stall while either port is still waiting
// Sequence per access: grant (IDLE/DONE) -> ISSUE -> DONE, rdy pulses the
// cycle after DONE, so back-to-back accesses run at one per two cycles.
module unified_mem_arbiter
  import unified_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                inst_ce_i,
  input  logic [ADDR_W-1:0]   inst_addr_i,
  output logic [DATA_W-1:0]   inst_data_o,
  output logic                inst_rdy_o,
  input  logic                data_ce_i,
  input  logic                data_we_i,
  input  logic [DATA_W/8-1:0] data_sel_i,
  input  logic [ADDR_W-1:0]   data_addr_i,
  input  logic [DATA_W-1:0]   data_wdata_i,
  output logic [DATA_W-1:0]   data_rdata_o,
  output logic                data_rdy_o,
  output logic                mem_ce_o,
  output logic                mem_we_o,
  output logic [DATA_W/8-1:0] mem_sel_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  output logic                stall_req_o
);

  localparam int SEL_W = DATA_W / 8;

  arb_state_e state;
  logic       grant_en;
  logic       excl_inst;
  logic       excl_data;
  logic       grant_inst;
  logic       grant_data;

  assign stall_req_o = (inst_ce_i & ~inst_rdy_o) | (data_ce_i & ~data_rdy_o);

  // A port is still holding ce for the access being completed both in its
  // DONE cycle and in the following rdy cycle; keep it out of arbitration.
  assign grant_en  = arb_can_grant(state);
  assign excl_inst = (state == ARB_DONE_I) | inst_rdy_o;
  assign excl_data = (state == ARB_DONE_D) | data_rdy_o;

  unified_mem_arb_grant #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_grant (
    .clk       (clk),
    .rst       (rst),
    .inst_req  (inst_ce_i),
    .data_req  (data_ce_i),
    .excl_inst (excl_inst),
    .excl_data (excl_data),
    .grant_en  (grant_en),
    .grant_inst(grant_inst),
    .grant_data(grant_data)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ARB_IDLE;
      mem_ce_o     <= 1'b0;
      mem_we_o     <= 1'b0;
      mem_sel_o    <= '0;
      mem_addr_o   <= '0;
      mem_wdata_o  <= '0;
      inst_rdy_o   <= 1'b0;
      data_rdy_o   <= 1'b0;
      inst_data_o  <= '0;
      data_rdata_o <= '0;
    end else begin
      inst_rdy_o <= 1'b0;
      data_rdy_o <= 1'b0;
      case (state)
        ARB_ISSUE_I: begin
          mem_ce_o <= 1'b0;
          mem_we_o <= 1'b0;
          state    <= ARB_DONE_I;
        end
        ARB_ISSUE_D: begin
          mem_ce_o <= 1'b0;
          mem_we_o <= 1'b0;
          state    <= ARB_DONE_D;
        end
        default: begin
          // IDLE, DONE_I, DONE_D: complete the previous access (if any) and
          // launch the next one in the same cycle.
          if (state == ARB_DONE_I) begin
            inst_rdy_o  <= 1'b1;
            inst_data_o <= mem_rdata_i;
          end
          if (state == ARB_DONE_D) begin
            data_rdy_o   <= 1'b1;
            data_rdata_o <= mem_rdata_i;
          end
          if (grant_data) begin
            mem_ce_o    <= 1'b1;
            mem_we_o    <= data_we_i;
            mem_sel_o   <= data_sel_i;
            mem_addr_o  <= data_addr_i;
            mem_wdata_o <= data_wdata_i;
            state       <= ARB_ISSUE_D;
          end else if (grant_inst) begin
            mem_ce_o   <= 1'b1;
            mem_we_o   <= 1'b0;
            mem_sel_o  <= {SEL_W{1'b1}};
            mem_addr_o <= inst_addr_i;
            state      <= ARB_ISSUE_I;
          end else begin
            mem_ce_o <= 1'b0;
            mem_we_o <= 1'b0;
            state    <= ARB_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
module tb_unified_mem_arbiter;
  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        inst_ce_i, data_ce_i, data_we_i;
  logic [31:0] inst_addr_i, data_addr_i, data_wdata_i;
  logic [3:0]  data_sel_i;
  logic [31:0] inst_data_o, data_rdata_o, mem_addr_o, mem_wdata_o, mem_rdata_i;
  logic        inst_rdy_o, data_rdy_o, mem_ce_o, mem_we_o, stall_req_o;
  logic [3:0]  mem_sel_o;

  unified_mem_arbiter #(.ADDR_W(32), .DATA_W(32), .STARVE_LIMIT(LIMIT)) dut (
    .clk(clk), .rst(rst),
    .inst_ce_i(inst_ce_i), .inst_addr_i(inst_addr_i), .inst_data_o(inst_data_o), .inst_rdy_o(inst_rdy_o),
    .data_ce_i(data_ce_i), .data_we_i(data_we_i), .data_sel_i(data_sel_i), .data_addr_i(data_addr_i),
    .data_wdata_i(data_wdata_i), .data_rdata_o(data_rdata_o), .data_rdy_o(data_rdy_o),
    .mem_ce_o(mem_ce_o), .mem_we_o(mem_we_o), .mem_sel_o(mem_sel_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i), .stall_req_o(stall_req_o)
  );

  always #5 clk = ~clk;

  int errs = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_val(input int i);
    if (i == 4)  return 32'h3C01_1234;
    if (i == 64) return 32'h0;
    return (i * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  // ---------------- memory: synchronous read, byte-enable write ----------
  logic [31:0] mem [256];
  bit          mem_init = 0;
  always @(posedge clk) begin
    if (!mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] = init_val(i);
      mem_init = 1;
    end
    if (mem_ce_o) begin
      mem_rdata_i <= mem[mem_addr_o[9:2]];
      if (mem_we_o)
        for (int b = 0; b < 4; b++)
          if (mem_sel_o[b]) mem[mem_addr_o[9:2]][8*b +: 8] = mem_wdata_o[8*b +: 8];
    end else begin
      mem_rdata_i <= $urandom;
    end
  end

  // ---------------- reference model + per-cycle compare ------------------
  // Schedule view: a grant at cycle g puts the command on the bus at g+1,
  // frees the bus for the next grant at g+2, and the rdy pulse lands at g+3.
  // A port is ineligible from its grant through its rdy cycle.
  logic [31:0] sh [256];
  bit          sh_init = 0;
  int          cyc = 0, lg = -100, lp = 0, streak = 0;
  bit          m_ibusy = 0, m_dbusy = 0;
  logic [3:0]  e_ce = '0, e_we = '0, e_ir = '0, e_dr = '0, e_ld = '0;
  logic [31:0] e_addr [4], e_wd [4], e_rd [4];
  logic [3:0]  e_sel [4];

  always @(negedge clk) begin
    int s, s1, s3;
    bit ei, ed, gi, gd;
    logic [7:0] idx;
    if (!sh_init) begin
      for (int i = 0; i < 256; i++) sh[i] = init_val(i);
      sh_init = 1;
    end
    s = cyc % 4;
    if (!rst) begin
      chk("rst_mem_ce", 32'(mem_ce_o), 32'h0);
      chk("rst_mem_we", 32'(mem_we_o), 32'h0);
      chk("rst_rdy", 32'({inst_rdy_o, data_rdy_o}), 32'h0);
      chk("rst_stall", 32'(stall_req_o), 32'(inst_ce_i | data_ce_i));
      e_ce = '0; e_we = '0; e_ir = '0; e_dr = '0; e_ld = '0;
      lg = -100; lp = 0; streak = 0; m_ibusy = 0; m_dbusy = 0;
    end else begin
      chk("mem_ce", 32'(mem_ce_o), 32'(e_ce[s]));
      chk("mem_we", 32'(mem_we_o), 32'(e_we[s]));
      if (e_ce[s]) begin
        chk("mem_addr", mem_addr_o, e_addr[s]);
        chk("mem_sel", 32'(mem_sel_o), 32'(e_sel[s]));
        if (e_we[s]) chk("mem_wdata", mem_wdata_o, e_wd[s]);
      end
      chk("inst_rdy", 32'(inst_rdy_o), 32'(e_ir[s]));
      chk("data_rdy", 32'(data_rdy_o), 32'(e_dr[s]));
      if (e_ir[s]) begin chk("inst_data", inst_data_o, e_rd[s]); m_ibusy = 0; end
      if (e_dr[s]) begin
        if (e_ld[s]) chk("data_rdata", data_rdata_o, e_rd[s]);
        m_dbusy = 0;
      end
      chk("stall", 32'(stall_req_o), 32'((inst_ce_i & ~e_ir[s]) | (data_ce_i & ~e_dr[s])));
      // grant decision for this cycle
      ei = inst_ce_i && !(lp == 1 && cyc <= lg + 3);
      ed = data_ce_i && !(lp == 2 && cyc <= lg + 3);
      gi = 0; gd = 0;
      if (cyc >= lg + 2) begin
        if (ei && ed) begin
          if (streak == LIMIT) gi = 1; else gd = 1;
        end else begin
          gi = ei; gd = ed;
        end
      end
      if (gi || gd) begin
        s1 = (cyc + 1) % 4;
        s3 = (cyc + 3) % 4;
        e_ce[s1]   = 1'b1;
        e_addr[s1] = gi ? inst_addr_i : data_addr_i;
        e_we[s1]   = gd & data_we_i;
        e_sel[s1]  = gi ? 4'hF : data_sel_i;
        e_wd[s1]   = data_wdata_i;
        idx        = e_addr[s1][9:2];
        e_rd[s3]   = sh[idx];
        if (gi) begin
          e_ir[s3] = 1'b1; m_ibusy = 1;
        end else begin
          e_dr[s3] = 1'b1; e_ld[s3] = !data_we_i; m_dbusy = 1;
          if (data_we_i)
            for (int b = 0; b < 4; b++)
              if (data_sel_i[b]) sh[idx][8*b +: 8] = data_wdata_i[8*b +: 8];
        end
        lg = cyc;
        lp = gi ? 1 : 2;
      end
      if (!inst_ce_i || gi)          streak = 0;
      else if (gd && streak < LIMIT) streak++;
      e_ce[s] = 0; e_we[s] = 0; e_ir[s] = 0; e_dr[s] = 0; e_ld[s] = 0;
    end
    cyc++;
  end

  // ---------------- requesters -------------------------------------------
  bit          rnd_en = 0;
  bit          i_pend, d_pend, i_drop, d_drop, i_rdy_prev, d_rdy_prev;
  logic [31:0] i_addr, d_addr, d_wd;
  logic [3:0]  d_sel;
  logic        d_we;

  function automatic logic [31:0] rand_addr();
    return $urandom & 32'hFFFF_F0FC;
  endfunction

  task automatic drive();
    inst_ce_i    = i_pend & ~i_drop;
    inst_addr_i  = i_addr;
    data_ce_i    = d_pend & ~d_drop;
    data_we_i    = d_we;
    data_sel_i   = d_sel;
    data_addr_i  = d_addr;
    data_wdata_i = d_wd;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
    if (i_rdy_prev) begin i_pend = 0; i_drop = 0; end
    if (d_rdy_prev) begin d_pend = 0; d_drop = 0; end
    i_rdy_prev = inst_rdy_o;
    d_rdy_prev = data_rdy_o;
    if (rnd_en) begin
      if (!i_pend && $urandom_range(0, 2) == 0) begin i_pend = 1; i_addr = rand_addr(); end
      if (!d_pend && $urandom_range(0, 2) == 0) begin
        d_pend = 1; d_we = 1'($urandom_range(0, 1)); d_sel = 4'($urandom);
        d_addr = rand_addr(); d_wd = $urandom;
      end
      // after grant: scramble fields, occasionally drop ce early
      if (i_pend && m_ibusy) begin
        i_addr = rand_addr();
        if ($urandom_range(0, 15) == 0) i_drop = 1;
      end
      if (d_pend && m_dbusy) begin
        d_we = 1'($urandom_range(0, 1)); d_sel = 4'($urandom);
        d_addr = rand_addr(); d_wd = $urandom;
        if ($urandom_range(0, 15) == 0) d_drop = 1;
      end
    end
    drive();
  endtask

  task automatic wait_rdy(input bit dport, output bit got);
    got = 0;
    for (int k = 0; k < 10 && !got; k++) begin
      step();
      if (dport ? data_rdy_o : inst_rdy_o) got = 1;
    end
  endtask

  initial begin
    bit got, saw;
    rst = 0;
    i_pend = 1; i_addr = 32'h10; i_drop = 0; i_rdy_prev = 0;
    d_pend = 1; d_we = 0; d_sel = 4'hF; d_addr = 32'h20; d_wd = 0; d_drop = 0; d_rdy_prev = 0;
    drive();
    @(posedge clk); @(posedge clk); #2;
    chk("hold_rst_ce", 32'(mem_ce_o), 32'h0);
    chk("hold_rst_addr", mem_addr_o, 32'h0);
    chk("hold_rst_rdy", 32'({inst_rdy_o, data_rdy_o}), 32'h0);
    chk("hold_rst_stall", 32'(stall_req_o), 32'h1);
    rst = 1;                       // cycle 0
    step();                        // cycle 1: data granted first
    chk("rel_ce", 32'(mem_ce_o), 32'h1);
    chk("rel_addr", mem_addr_o, 32'h20);
    chk("rel_we", 32'(mem_we_o), 32'h0);
    step(); step();                // cycle 3: data rdy, fetch on the bus
    chk("load_rdy", 32'(data_rdy_o), 32'h1);
    chk("fetch_addr", mem_addr_o, 32'h10);
    chk("fetch_sel", 32'(mem_sel_o), 32'hF);
    chk("fetch_we", 32'(mem_we_o), 32'h0);
    step(); step();                // cycle 5: fetch rdy
    chk("fetch_rdy", 32'(inst_rdy_o), 32'h1);
    chk("fetch_data", inst_data_o, 32'h3C01_1234);
    chk("fetch_stall", 32'(stall_req_o), 32'h0);
    step();

    // store then load through the same word
    d_pend = 1; d_we = 1; d_sel = 4'b0011; d_addr = 32'h100; d_wd = 32'hDEAD_BEEF;
    step();                        // request visible
    step();                        // issue cycle
    chk("store_we", 32'(mem_we_o), 32'h1);
    chk("store_sel", 32'(mem_sel_o), 32'h3);
    chk("store_wdata", mem_wdata_o, 32'hDEAD_BEEF);
    step(); step();
    chk("store_rdy", 32'(data_rdy_o), 32'h1);
    step();
    d_pend = 1; d_we = 0; d_sel = 4'hF; d_addr = 32'h100;
    wait_rdy(1'b1, got);
    chk("load_done", 32'(got), 32'h1);
    chk("load_data", data_rdata_o, 32'h0000_BEEF);

    // randomized traffic
    rnd_en = 1;
    repeat (3000) step();
    rnd_en = 0;
    got = 0;
    for (int k = 0; k < 40 && !got; k++) begin
      step();
      if (!i_pend && !d_pend) got = 1;
    end
    chk("drain", 32'(got), 32'h1);
    step(); step();

    // reset during the ISSUE_D cycle of a load
    d_pend = 1; d_we = 0; d_sel = 4'hF; d_addr = 32'h100; d_drop = 0;
    step();
    step();
    chk("mid_issue", 32'(mem_ce_o), 32'h1);
    rst = 0;
    #1;
    chk("mid_rst_ce", 32'(mem_ce_o), 32'h0);
    saw = 0;
    repeat (3) begin step(); if (data_rdy_o) saw = 1; end
    chk("mid_no_rdy", 32'(saw), 32'h0);
    rst = 1;
    wait_rdy(1'b1, got);
    chk("mid_reissue", 32'(got), 32'h1);
    chk("mid_rdata", data_rdata_o, 32'h0000_BEEF);
    step(); step();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
